// File: rtl/rgmii_rx_decoder.sv
// rgmii_rx_decoder: decodes RGMII IDDR samples into an AXI-Stream of frame bytes, with no backpressure.
// Define RGMII_RX_STATS_EN to build the good/bad frame counters; without it both counter ports read 0.
module rgmii_rx_decoder #(
  parameter int MAX_FRAME_BYTES = 1522,
  parameter int MAX_PREAMBLE = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_gmii_mode,
  input  logic [4:0]  q1,
  input  logic [4:0]  q2,
  output logic [7:0]  m_rx_axis_tdata,
  output logic        m_rx_axis_tvalid,
  output logic        m_rx_axis_tlast,
  output logic        m_rx_axis_tuser,
  output logic [15:0] o_frame_cnt,
  output logic [15:0] o_err_cnt
);
  localparam int PW = $clog2(MAX_PREAMBLE + 1);
  localparam int BW = $clog2(MAX_FRAME_BYTES + 2);
  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;
  state_t state, state_n;
  logic dv, er, mode, phase, lo_er, d_vld, d_dv, d_stb, d_er, armed;
  logic [3:0] lo;
  logic [7:0] d_byte, hold, hold_n;
  logic have, have_n, err, err_n, beat, last, user;
  logic [PW-1:0] pre_cnt, pre_cnt_n;
  logic [BW-1:0] byte_cnt, byte_cnt_n;
  assign dv = q1[4];
  assign er = q1[4] ^ q2[4];
  // d_stb marks a complete byte; in 10/100 mode an error on either nibble taints the byte
  always_ff @(posedge clk) begin
    if (reset) begin
      mode <= 1'b0;
      phase <= 1'b0;
      lo <= '0;
      lo_er <= 1'b0;
      d_vld <= 1'b0;
      d_dv <= 1'b0;
      d_stb <= 1'b0;
      d_er <= 1'b0;
      d_byte <= '0;
      armed <= 1'b0;
    end else begin
      if (state == IDLE && !dv) mode <= i_gmii_mode;
      d_vld <= 1'b1;
      d_dv <= dv;
      armed <= armed | (d_vld & ~d_dv);
      if (mode) begin
        d_stb <= dv;
        d_er <= er;
        d_byte <= {q2[3:0], q1[3:0]};
        phase <= 1'b0;
      end else if (dv && (!d_dv || !phase)) begin
        lo <= q1[3:0];
        lo_er <= er;
        phase <= 1'b1;
        d_stb <= 1'b0;
        d_er <= er;
      end else begin
        d_stb <= dv;
        d_er <= er | (lo_er & dv);
        d_byte <= {q1[3:0], lo};
        phase <= 1'b0;
      end
    end
  end
  always_comb begin
    state_n = state;
    hold_n = hold;
    have_n = have;
    err_n = err;
    pre_cnt_n = pre_cnt;
    byte_cnt_n = byte_cnt;
    beat = 1'b0;
    last = 1'b0;
    user = 1'b0;
    case (state)
      IDLE: if (armed && d_dv && d_stb) begin
        state_n = (!d_er && d_byte == 8'h55) ? PREAMBLE : DROP;
        pre_cnt_n = PW'(1);
      end
      PREAMBLE: if (!d_dv) state_n = IDLE;
        else if (d_stb) begin
          if (!d_er && d_byte == 8'hD5) begin
            state_n = DATA;
            have_n = 1'b0;
            err_n = 1'b0;
            byte_cnt_n = '0;
          end else if (!d_er && d_byte == 8'h55 && pre_cnt != PW'(MAX_PREAMBLE)) pre_cnt_n = pre_cnt + 1'b1;
          else state_n = DROP;
        end
      DATA: if (!d_dv) begin
          state_n = IDLE;
          beat = have;
          last = have;
          user = err;
        end else if (d_stb) begin
          err_n = err | d_er;
          byte_cnt_n = byte_cnt + 1'b1;
          hold_n = d_byte;
          have_n = 1'b1;
          beat = have || byte_cnt == BW'(MAX_FRAME_BYTES);
          last = byte_cnt == BW'(MAX_FRAME_BYTES);
          user = last;
          state_n = last ? DROP : DATA;
        end
      default: if (!d_dv) state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      hold <= '0;
      have <= 1'b0;
      err <= 1'b0;
      pre_cnt <= '0;
      byte_cnt <= '0;
      m_rx_axis_tdata <= '0;
      m_rx_axis_tvalid <= 1'b0;
      m_rx_axis_tlast <= 1'b0;
      m_rx_axis_tuser <= 1'b0;
    end else begin
      state <= state_n;
      hold <= hold_n;
      have <= have_n;
      err <= err_n;
      pre_cnt <= pre_cnt_n;
      byte_cnt <= byte_cnt_n;
      m_rx_axis_tdata <= beat ? hold : 8'h00;
      m_rx_axis_tvalid <= beat;
      m_rx_axis_tlast <= beat & last;
      m_rx_axis_tuser <= beat & last & user;
    end
  end
`ifdef RGMII_RX_STATS_EN
  logic good_inc, bad_inc;
  // bad frames: a dropped start, an SFD with no payload, or an errored/truncated last beat
  assign good_inc = beat & last & ~user;
  assign bad_inc = ((state == IDLE || state == PREAMBLE) && state_n == DROP) ||
                   (state == DATA && !d_dv && !have) || (beat & last & user);
  always_ff @(posedge clk) begin
    if (reset) begin
      o_frame_cnt <= '0;
      o_err_cnt <= '0;
    end else begin
      if (good_inc && o_frame_cnt != 16'hFFFF) o_frame_cnt <= o_frame_cnt + 1'b1;
      if (bad_inc && o_err_cnt != 16'hFFFF) o_err_cnt <= o_err_cnt + 1'b1;
    end
  end
`else
  assign o_frame_cnt = '0;
  assign o_err_cnt = '0;
`endif
endmodule

// File: tb/tb_rgmii_rx_decoder.sv
// tb_rgmii_rx_decoder: directed frames against a frame-level model of the expected beat stream and counters.
module tb_rgmii_rx_decoder;
  localparam int MAXF = 1522;
  localparam int MAXP = 15;
  localparam int NOCUT = 1 << 30;
`ifdef RGMII_RX_STATS_EN
  localparam int ST = 1;
`else
  localparam int ST = 0;
`endif
  typedef struct {
    int c;
    logic [7:0] d;
    logic l;
    logic u;
  } beat_t;
  logic clk = 1'b0, reset = 1'b1, mode = 1'b1;
  logic [4:0] q1 = '0, q2 = '0;
  logic [7:0] tdata;
  logic tvalid, tlast, tuser;
  logic [15:0] fcnt, ecnt;
  int checks = 0, errors = 0, cyc = 0;
  int nbeat = 0, nlast = 0, nuser = 0;
  logic [7:0] lastd = '0;
  int exp_f = 0, exp_e = 0;
  beat_t expq[$];
  logic [7:0] fb[$];
  logic fe[$];

  rgmii_rx_decoder dut (
    .clk(clk), .reset(reset), .i_gmii_mode(mode), .q1(q1), .q2(q2),
    .m_rx_axis_tdata(tdata), .m_rx_axis_tvalid(tvalid), .m_rx_axis_tlast(tlast),
    .m_rx_axis_tuser(tuser), .o_frame_cnt(fcnt), .o_err_cnt(ecnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // every cycle: either the scheduled beat is on the bus, or the bus is all zero
  always @(negedge clk) begin
    while (expq.size() > 0 && expq[0].c < cyc) begin
      checks++;
      errors++;
      $display("FAIL missed_beat: beat due at cycle %0d data %02h never seen", expq[0].c, expq[0].d);
      void'(expq.pop_front());
    end
    checks++;
    if (expq.size() > 0 && expq[0].c == cyc) begin
      if (tvalid !== 1'b1 || tdata !== expq[0].d || tlast !== expq[0].l || tuser !== expq[0].u) begin
        errors++;
        $display("FAIL beat@%0d: got v=%b d=%02h l=%b u=%b expected v=1 d=%02h l=%b u=%b",
                 cyc, tvalid, tdata, tlast, tuser, expq[0].d, expq[0].l, expq[0].u);
      end
      void'(expq.pop_front());
    end else if ({tvalid, tlast, tuser, tdata} !== 11'b0) begin
      errors++;
      $display("FAIL idle@%0d: got v=%b d=%02h l=%b u=%b expected all zero", cyc, tvalid, tdata, tlast, tuser);
    end
    if (tvalid === 1'b1) begin
      nbeat++;
      lastd = tdata;
      nlast += int'(tlast);
      nuser += int'(tuser);
    end
  end

  function automatic int cap(input bit g, input int c0, input int i);
    return g ? c0 + i : c0 + 2 * i + 1;
  endfunction

  // frame-level model: classify preamble, then schedule payload beats from the capture cycle of the following byte
  task automatic plan(input bit g, input int c0, input int cut);
    int n, p, s, m, lim, due;
    bit anyer, trunc;
    n = fb.size();
    p = 0;
    anyer = 1'b0;
    while (p < n && p <= MAXP && fb[p] == 8'h55 && !fe[p]) p++;
    if (p > MAXP || (p < n && (p == 0 || fb[p] != 8'hD5 || fe[p]))) begin
      if (cut == NOCUT) exp_e++;
      return;
    end
    if (p == n) return;
    s = p + 1;
    m = n - s;
    if (m == 0) begin
      if (cut == NOCUT) exp_e++;
      return;
    end
    for (int k = s; k < n; k++) anyer |= fe[k];
    trunc = m > MAXF;
    lim = trunc ? MAXF : m;
    for (int k = 0; k < lim; k++) begin
      due = 1 + ((k + 1 < m) ? cap(g, c0, s + k + 1) : (g ? c0 + n : c0 + 2 * n));
      if (due < cut) expq.push_back('{due, fb[s + k], logic'(k == lim - 1), logic'(k == lim - 1 && (anyer || trunc))});
    end
    if (cut == NOCUT) begin
      if (anyer || trunc) exp_e++;
      else exp_f++;
    end
  endtask

  task automatic frame(input int np, input bit sfd, input int n, input int erk);
    fb.delete();
    fe.delete();
    repeat (np) begin
      fb.push_back(8'h55);
      fe.push_back(1'b0);
    end
    if (sfd) begin
      fb.push_back(8'hD5);
      fe.push_back(1'b0);
    end
    for (int k = 1; k <= n; k++) begin
      fb.push_back(8'(k));
      fe.push_back(k == erk);
    end
  endtask

  // lead-in carries one false-carrier sample (dv=0, er=1) that must be ignored
  task automatic send(input bit g, input int cutoff, input int flip);
    int c0, cut;
    @(negedge clk);
    mode = g;
    q1 = 5'h00;
    q2 = 5'h10;
    repeat (3) @(negedge clk);
    q2 = 5'h00;
    c0 = cyc + 1;
    cut = (cutoff < 0) ? NOCUT : c0 + cutoff;
    plan(g, c0, cut);
    for (int i = 0; i < fb.size(); i++) begin
      reset = (cyc + 1 == cut);
      if (i == flip) mode = ~g;
      q1 = {1'b1, fb[i][3:0]};
      q2 = {~fe[i], g ? fb[i][7:4] : 4'($urandom)};
      @(negedge clk);
      if (!g) begin
        q1 = {1'b1, fb[i][7:4]};
        q2 = {~fe[i], 4'($urandom)};
        @(negedge clk);
      end
    end
    reset = 1'b0;
    q1 = 5'h00;
    q2 = 5'h00;
    if (cutoff >= 0) begin
      exp_f = 0;
      exp_e = 0;
    end
    repeat (6) @(negedge clk);
    chk("model_frames", fcnt, ST * exp_f);
    chk("model_errs", ecnt, ST * exp_e);
  endtask

  initial begin
    int b0, l0, u0;
    repeat (3) @(negedge clk);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_tuser", tuser, 0);
    chk("rst_frames", fcnt, 0);
    chk("rst_errs", ecnt, 0);
    reset = 1'b0;
    b0 = nbeat; l0 = nlast; u0 = nuser;
    frame(7, 1, 64, 0);
    send(1, -1, -1);
    chk("gig_beats", nbeat - b0, 64);
    chk("gig_lastd", lastd, 8'h40);
    chk("gig_tlast", nlast - l0, 1);
    chk("gig_tuser", nuser - u0, 0);
    chk("gig_frames", fcnt, ST);
    b0 = nbeat; l0 = nlast;
    frame(7, 1, 2, 0);
    send(0, -1, -1);
    chk("mii_beats", nbeat - b0, 2);
    chk("mii_lastd", lastd, 8'h02);
    chk("mii_tlast", nlast - l0, 1);
    chk("mii_frames", fcnt, 2 * ST);
    b0 = nbeat; u0 = nuser;
    frame(7, 1, 10, 5);
    send(1, -1, 4);
    chk("er_beats", nbeat - b0, 10);
    chk("er_tuser", nuser - u0, 1);
    chk("er_errs", ecnt, ST);
    b0 = nbeat; u0 = nuser;
    frame(7, 1, 1600, 0);
    send(1, -1, -1);
    chk("long_beats", nbeat - b0, 1522);
    chk("long_lastd", lastd, 8'hF2);
    chk("long_tuser", nuser - u0, 1);
    chk("long_errs", ecnt, 2 * ST);
    b0 = nbeat; l0 = nlast;
    frame(7, 1, 30, 0);
    send(1, 19, -1);
    chk("rst_mid_beats", nbeat - b0, 9);
    chk("rst_mid_tlast", nlast - l0, 0);
    chk("rst_mid_frames", fcnt, 0);
    chk("rst_mid_errs", ecnt, 0);
    b0 = nbeat;
    frame(7, 1, 5, 0);
    send(1, -1, -1);
    chk("post_rst_beats", nbeat - b0, 5);
    chk("post_rst_frames", fcnt, ST);
    b0 = nbeat;
    frame(16, 1, 4, 0);
    send(1, -1, -1);
    chk("pre16_beats", nbeat - b0, 0);
    chk("pre16_errs", ecnt, ST);
    b0 = nbeat;
    frame(15, 1, 3, 0);
    send(1, -1, -1);
    chk("pre15_beats", nbeat - b0, 3);
    b0 = nbeat;
    frame(7, 1, 0, 0);
    send(1, -1, -1);
    chk("sfd_only_beats", nbeat - b0, 0);
    chk("sfd_only_errs", ecnt, 2 * ST);
    b0 = nbeat;
    frame(0, 0, 5, 0);
    send(0, -1, -1);
    chk("bad_start_beats", nbeat - b0, 0);
    b0 = nbeat;
    frame(7, 1, 4, 0);
    fe[3] = 1'b1;
    send(1, -1, -1);
    chk("pre_er_beats", nbeat - b0, 0);
    chk("pre_er_errs", ecnt, 4 * ST);
    chk("queue_drained", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
